// File: rtl/sys_array_host_ctrl.sv
// Host-side initiator for sys_array_fetcher: collects A then B from an element stream,
// launches the computation, waits for the result and streams it back out row-major.
module sys_array_host_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int ARRAY_W     = 4,
   parameter int ARRAY_L     = 4,
   parameter int WAIT_CYCLES = ARRAY_L + 2*ARRAY_W + 4
) (
   input  logic                                             clk,
   input  logic                                             reset_n,
   input  logic                                             in_valid,
   output logic                                             in_ready,
   input  logic [DATA_WIDTH-1:0]                            in_data,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic [2*DATA_WIDTH-1:0]                          out_data,
   output logic                                             out_last,
   output logic                                             busy,
   output logic                                             load_params,
   output logic                                             start_comp,
   output logic [ARRAY_W-1:0][ARRAY_L-1:0][DATA_WIDTH-1:0]  data_a,
   output logic [ARRAY_W-1:0][ARRAY_L-1:0][DATA_WIDTH-1:0]  data_b,
   input  logic                                             fetch_ready,
   input  logic [ARRAY_W-1:0][ARRAY_W-1:0][2*DATA_WIDTH-1:0] fetch_data
);

   localparam int NA        = ARRAY_W * ARRAY_L;
   localparam int NR        = ARRAY_W * ARRAY_W;
   localparam int IDX_W     = $clog2(NA + 1);
   localparam int K_W       = $clog2(NR + 1);
   localparam int WC_W      = $clog2(WAIT_CYCLES + 1);
   localparam int IDX_SEL_W = $clog2(NA);
   localparam int K_SEL_W   = $clog2(NR);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NA - 1);
   localparam logic [K_W-1:0]   K_LAST   = K_W'(NR - 1);
   localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(WAIT_CYCLES);
   localparam logic [WC_W-1:0]  WC_DONE  = WC_W'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_LOAD_A,
      S_LOAD_B,
      S_PARAM,
      S_START,
      S_WAIT,
      S_DRAIN
   } state_t;

   state_t                                r_state;
   state_t                                w_state_next;
   logic [IDX_W-1:0]                      r_idx;
   logic [K_W-1:0]                        r_k;
   logic [WC_W-1:0]                       r_wcnt;
   // Flat row-major buffers; element e lines up with [e/ARRAY_L][e%ARRAY_L] of the packed ports.
   logic [NA-1:0][DATA_WIDTH-1:0]         r_buf_a;
   logic [NA-1:0][DATA_WIDTH-1:0]         r_buf_b;
   logic [NR-1:0][2*DATA_WIDTH-1:0]       r_result;

   logic                                  w_idx_last;
   logic                                  w_k_last;
   logic                                  w_capture;
   logic [IDX_SEL_W-1:0]                  w_idx_sel;
   logic [K_SEL_W-1:0]                    w_k_sel;

   assign w_idx_last = (r_idx == IDX_LAST);
   assign w_k_last   = (r_k == K_LAST);
   assign w_idx_sel  = r_idx[IDX_SEL_W-1:0];
   assign w_k_sel    = r_k[K_SEL_W-1:0];
   // fetch_ready is sticky from earlier jobs, so the minimum wait must be honoured on its own.
   assign w_capture  = (r_state == S_WAIT) && (r_wcnt >= WC_DONE) && fetch_ready;

   assign data_a   = r_buf_a;
   assign data_b   = r_buf_b;
   assign out_data = r_result[w_k_sel];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_LOAD_A;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_last     = 1'b0;
      load_params  = 1'b0;
      start_comp   = 1'b0;
      busy         = 1'b1;
      case (r_state)
         S_LOAD_A: begin
            busy     = 1'b0;
            in_ready = reset_n;
            if (in_valid && w_idx_last) begin
               w_state_next = S_LOAD_B;
            end
         end
         S_LOAD_B: begin
            in_ready = reset_n;
            if (in_valid && w_idx_last) begin
               w_state_next = S_PARAM;
            end
         end
         S_PARAM: begin
            load_params  = 1'b1;
            w_state_next = S_START;
         end
         S_START: begin
            start_comp   = 1'b1;
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (w_capture) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            out_last  = w_k_last;
            if (out_ready && w_k_last) begin
               w_state_next = S_LOAD_A;
            end
         end
         default: begin
            w_state_next = S_LOAD_A;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idx    <= '0;
         r_k      <= '0;
         r_wcnt   <= '0;
         r_buf_a  <= '0;
         r_buf_b  <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_LOAD_A: begin
               if (in_valid) begin
                  r_buf_a[w_idx_sel] <= in_data;
                  r_idx              <= w_idx_last ? '0 : r_idx + IDX_W'(1);
               end
            end
            S_LOAD_B: begin
               if (in_valid) begin
                  r_buf_b[w_idx_sel] <= in_data;
                  r_idx              <= w_idx_last ? '0 : r_idx + IDX_W'(1);
               end
            end
            S_START: begin
               r_wcnt <= '0;
            end
            S_WAIT: begin
               if (r_wcnt != WC_MAX) begin
                  r_wcnt <= r_wcnt + WC_W'(1);
               end
               if (w_capture) begin
                  r_result <= fetch_data;
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  r_k <= w_k_last ? '0 : r_k + K_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sys_array_host_ctrl.sv
// Randomized self-checking bench for sys_array_host_ctrl with a simple sticky-ready fetcher model.
module tb_sys_array_host_ctrl;

   localparam int DW   = 8;
   localparam int AW   = 4;
   localparam int AL   = 4;
   localparam int WAIT = AL + 2*AW + 4;
   localparam int NE   = AW * AL;
   localparam int NR   = AW * AW;

   logic                             clk = 1'b0;
   logic                             reset_n = 1'b0;
   logic                             in_valid = 1'b0;
   logic                             in_ready;
   logic [DW-1:0]                    in_data = '0;
   logic                             out_valid;
   logic                             out_ready = 1'b0;
   logic [2*DW-1:0]                  out_data;
   logic                             out_last;
   logic                             busy;
   logic                             load_params;
   logic                             start_comp;
   logic [AW-1:0][AL-1:0][DW-1:0]    data_a;
   logic [AW-1:0][AL-1:0][DW-1:0]    data_b;
   logic                             fetch_ready = 1'b0;
   logic [AW-1:0][AW-1:0][2*DW-1:0]  fetch_data = '0;

   int         n_checks = 0;
   int         n_errors = 0;
   int         job_no = 0;
   int         base = 0;
   logic [7:0] m_a [NE];
   logic [7:0] m_b [NE];

   always #5 clk = ~clk;

   sys_array_host_ctrl #(
      .DATA_WIDTH (DW),
      .ARRAY_W    (AW),
      .ARRAY_L    (AL),
      .WAIT_CYCLES(WAIT)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .load_params(load_params),
      .start_comp (start_comp),
      .data_a     (data_a),
      .data_b     (data_b),
      .fetch_ready(fetch_ready),
      .fetch_data (fetch_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected result element k of the current job, row-major.
   function automatic logic [15:0] exp_res(input int k);
      return 16'(base + 16*(k/AW) + (k%AW));
   endfunction

   task automatic check_bufs(input string where);
      for (int e = 0; e < NE; e++) begin
         chk($sformatf("%s data_a[%0d][%0d]", where, e/AL, e%AL), 32'(data_a[e/AL][e%AL]), 32'(m_a[e]));
         chk($sformatf("%s data_b[%0d][%0d]", where, e/AL, e%AL), 32'(data_b[e/AL][e%AL]), 32'(m_b[e]));
      end
   endtask

   task automatic check_zero(input string where);
      chk({where, " in_ready"},    32'(in_ready),    32'(0));
      chk({where, " busy"},        32'(busy),        32'(0));
      chk({where, " out_valid"},   32'(out_valid),   32'(0));
      chk({where, " out_last"},    32'(out_last),    32'(0));
      chk({where, " load_params"}, 32'(load_params), 32'(0));
      chk({where, " start_comp"},  32'(start_comp),  32'(0));
      chk({where, " out_data"},    32'(out_data),    32'(0));
      chk({where, " data_a_any"},  32'(|data_a),     32'(0));
      chk({where, " data_b_any"},  32'(|data_b),     32'(0));
   endtask

   task automatic load_phase(input int bubble_pct);
      int idx = 0;
      int n = 0;
      while (idx < 2*NE && n < 2000) begin
         @(negedge clk);
         n++;
         in_valid = ($urandom_range(0, 99) >= bubble_pct);
         in_data  = (idx < NE) ? m_a[idx] : m_b[idx-NE];
         #1;
         chk("load in_ready", 32'(in_ready), 32'(1));
         chk("load busy", 32'(busy), 32'(idx >= NE));
         if (in_valid && in_ready) idx++;
      end
      if (idx < 2*NE) chk("load_timeout", 32'(idx), 32'(2*NE));
   endtask

   task automatic launch_phase();
      for (int i = 0; i < AW; i++)
         for (int j = 0; j < AW; j++)
            fetch_data[i][j] = 16'(base + 16*i + j);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      #1;
      chk("param load_params", 32'(load_params), 32'(1));
      chk("param start_comp",  32'(start_comp),  32'(0));
      chk("param in_ready",    32'(in_ready),    32'(0));
      chk("param busy",        32'(busy),        32'(1));
      check_bufs("param");
      @(negedge clk);
      #1;
      chk("start load_params", 32'(load_params), 32'(0));
      chk("start start_comp",  32'(start_comp),  32'(1));
   endtask

   // r_delay: cycle (counted from the start_comp cycle) at which fetch_ready rises; <=0 means already high.
   task automatic wait_phase(input int r_delay, output int lat);
      lat = -1;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         if (c == r_delay) fetch_ready = 1'b1;
         #1;
         chk("wait strobes", 32'({load_params, start_comp, in_ready}), 32'(0));
         chk("wait busy", 32'(busy), 32'(1));
         if (out_valid) begin
            lat = c;
            break;
         end
      end
      if (lat < 0) chk("wait_timeout", 32'(0), 32'(1));
   endtask

   task automatic drain_phase(input int mode);
      int k = 0;
      int n = 0;
      while (k < NR && n < 400) begin
         chk("drain out_valid", 32'(out_valid), 32'(1));
         chk($sformatf("out_data[%0d]", k), 32'(out_data), 32'(exp_res(k)));
         chk($sformatf("out_last[%0d]", k), 32'(out_last), 32'(k == NR-1));
         if (out_ready) k++;
         @(negedge clk);
         n++;
         in_valid = 1'b0;
         case (mode)
            0:       out_ready = (n % 2 == 1);
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
      end
      if (k < NR) chk("drain_timeout", 32'(k), 32'(NR));
      out_ready = 1'b0;
      chk("idle busy",      32'(busy),      32'(0));
      chk("idle out_valid", 32'(out_valid), 32'(0));
      chk("idle in_ready",  32'(in_ready),  32'(1));
      check_bufs("post");
   endtask

   task automatic run_job(input int bubble_pct, input int r_delay, input int mode);
      int lat;
      int exp_lat;
      load_phase(bubble_pct);
      launch_phase();
      wait_phase(r_delay, lat);
      exp_lat = ((r_delay > WAIT) ? r_delay : WAIT) + 1;
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("latency_min", 32'(lat >= WAIT), 32'(1));
      drain_phase(mode);
      job_no++;
      $display("job %0d: base %0d, result after %0d cycles, drain mode %0d", job_no, base, lat, mode);
   endtask

   task automatic fill_seq();
      for (int e = 0; e < NE; e++) begin
         m_a[e] = 8'(e + 1);
         m_b[e] = 8'(e + 17);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("release in_ready", 32'(in_ready), 32'(1));
      chk("release busy",     32'(busy),     32'(0));

      // Job 1: sequential operands, fetcher becomes ready late.
      fill_seq();
      base = 0;
      run_job(0, 25, 0);

      // Job 2: bubbles on input, fetch_ready already held from the previous job.
      run_job(50, -1, 0);

      // Abort mid-WAIT with random operands.
      for (int e = 0; e < NE; e++) begin
         m_a[e] = 8'($urandom);
         m_b[e] = 8'($urandom);
      end
      load_phase(30);
      launch_phase();
      repeat (6) @(negedge clk);
      @(negedge clk);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      #1;
      check_zero("abort");
      $display("abort: reset asserted during WAIT");
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("abort release in_ready", 32'(in_ready), 32'(1));

      // Job after abort must match the sequential job.
      fill_seq();
      base = 0;
      run_job(0, -1, 0);

      // Back-to-back: random A, B all zero, random downstream stalls.
      for (int e = 0; e < NE; e++) begin
         m_a[e] = 8'($urandom);
         m_b[e] = 8'(0);
      end
      base = int'($urandom_range(0, 4095));
      run_job(0, -1, 2);

      // Fully random job, downstream always ready.
      for (int e = 0; e < NE; e++) begin
         m_a[e] = 8'($urandom);
         m_b[e] = 8'($urandom);
      end
      base = int'($urandom_range(0, 4095));
      run_job(20, -1, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
